// File: rtl/event_stretcher_pkg.sv
// Shared constants for the event stretcher: FSM state encoding and default widths.
package event_stretcher_pkg;

  // FSM state encoding (kept as plain constants so older tools and wrappers can reuse it)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // Default hold/gap timer width
  localparam int CNT_W_DEFAULT = 24;

  // Default pending-event counter width
  localparam int PEND_W_DEFAULT = 4;

endpackage

// File: rtl/event_stretcher_if.sv
// Event-in / pulse-out bundle of the event stretcher.
// The master side produces events and observes the stretched pulse and status.
interface event_stretcher_if
  import event_stretcher_pkg::*;
#(
  parameter int PEND_W = PEND_W_DEFAULT
);

  logic              ev_i;
  logic              o;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (
    output ev_i,
    input  o,
    input  busy,
    input  pending,
    input  overflow
  );

  modport slave (
    input  ev_i,
    output o,
    output busy,
    output pending,
    output overflow
  );

endinterface

// File: rtl/event_stretcher_rise_detect.sv
// One-cycle rise detector. The previous-value register resets to 1 so that an
// input already high when reset releases is not reported as a rising edge.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  // Previous input value for the next cycle's comparison
  always_comb begin
    prev_d = d;
  end

  // Register the previous input; reset to 1 to suppress a spurious edge
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/event_stretcher.sv
// Event stretcher: turns each rising edge of ev_i into a HOLD_CYCLES-long high
// pulse followed by at least GAP_CYCLES low. Edges arriving while a pulse is in
// progress are queued in a saturating counter and replayed back to back.
// All outputs are registered; ev_i reaches them only through flops.
module event_stretcher
  import event_stretcher_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 1000000,
  parameter int PEND_W      = PEND_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  event_stretcher_if.slave  bus
);

  // Terminal counts; the timer is cleared on every state entry so it never wraps
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMER_ONE = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  logic              ev_rise;

  logic [1:0]        state_d,    state_q;
  logic [CNT_W-1:0]  timer_d,    timer_q;
  logic [PEND_W-1:0] pending_d,  pending_q;
  logic              o_d,        o_q;
  logic              busy_d,     busy_q;
  logic              overflow_d, overflow_q;

  logic              consumed;
  logic              inc;
  logic              dec;

  rise_detect u_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.ev_i),
    .rise (ev_rise)
  );

  // Next-state, timer and pending-queue logic
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q + TIMER_ONE;
    pending_d  = pending_q;
    overflow_d = 1'b0;
    consumed   = 1'b0;
    dec        = 1'b0;
    inc        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Queue is always empty here, so an edge starts a pulse directly
        timer_d = '0;
        if (ev_rise) begin
          state_d  = S_HOLD;
          consumed = 1'b1;
        end
      end
      S_HOLD: begin
        if (timer_q == HOLD_LAST) begin
          state_d = S_GAP;
          timer_d = '0;
        end
      end
      S_GAP: begin
        if (timer_q == GAP_LAST) begin
          timer_d = '0;
          if (pending_q != '0) begin
            // Replay from the queue; a simultaneous edge is queued instead
            state_d = S_HOLD;
            dec     = 1'b1;
          end else if (ev_rise) begin
            state_d  = S_HOLD;
            consumed = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    inc = ev_rise & ~consumed;

    // inc and dec in the same cycle cancel out
    if (inc && !dec) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + PEND_ONE;
      end
    end else if (dec && !inc) begin
      pending_d = pending_q - PEND_ONE;
    end

    o_d    = (state_d == S_HOLD);
    busy_d = (state_d != S_IDLE);
  end

  // State, timer, queue and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      o_q        <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      o_q        <= o_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.o        = o_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;

endmodule
